instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the reset; reset is synchronous and active-high.
REQ-004 imem_req  output  1  SHALL signal that a fetch is outstanding.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_ack  input  1  SHALL mark imem_rdata valid for the outstanding fetch.
REQ-007 imem_rdata  input  32  SHALL carry the instruction word.
REQ-008 stall  input  1  SHALL indicate the downstream decode/execute stage cannot accept the held instruction.
REQ-009 branch_taken  input  1  SHALL request a redirect to branch_target.
REQ-010 branch_target  input  32  SHALL carry the redirect address; bits [1:0] are forced to 00.
REQ-011 instr  output  32  SHALL carry the held instruction.
REQ-012 instr_valid  output  1  SHALL mark instr as valid.
REQ-013 opcode  output  6  SHALL equal instr[31:26], driving the main control decoder.
REQ-014 pc  output  32  SHALL carry the address of instr.
REQ-015 pc_plus4  output  32  SHALL equal pc+4, modulo 2^32.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and HOLD.
REQ-017 In IDLE, the FSM SHALL move to REQ on the next cycle, with imem_req=1 and imem_addr=fetch_addr.
REQ-018 In REQ, imem_req SHALL stay 1 and imem_addr SHALL stay stable until imem_ack is seen.
REQ-019 In REQ, imem_ack=1 with no kill pending and branch_taken=0 SHALL capture the fetch on the same edge:
- instr<=imem_rdata, pc<=fetch_addr, instr_valid<=1, imem_req<=0, next state HOLD.
REQ-020 Minimum fetch latency SHALL be one cycle, from the imem_req edge to instr_valid=1 when imem_ack is returned in the same cycle.
REQ-021 In HOLD with stall=1, instr, pc and instr_valid SHALL hold, and branch_taken SHALL be ignored.
REQ-022 In HOLD with stall=0, the instruction SHALL be consumed on that edge:
- instr_valid<=0, next state REQ, imem_req<=1.
- fetch_addr<=branch_target if branch_taken, otherwise pc+4.
REQ-023 In REQ, branch_taken=1 together with imem_ack=1 SHALL discard imem_rdata, set fetch_addr<=branch_target, and keep imem_req=1.
REQ-024 In REQ, branch_taken=1 with imem_ack=0 SHALL set kill<=1 and redirect_addr<=branch_target, keeping imem_addr unchanged.
REQ-025 A later branch_taken while kill=1 SHALL overwrite redirect_addr.
REQ-026 imem_ack while kill=1 SHALL discard the data and set fetch_addr<=redirect_addr and kill<=0, with imem_req remaining 1.
REQ-027 Address arithmetic SHALL wrap: pc=32'hFFFF_FFFC gives pc_plus4=0, and the next sequential fetch is 0.
REQ-028 instr_valid SHALL never be 1 in IDLE or REQ.
REQ-029 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-030 reset=1 SHALL, on the next edge, set the following:
- state=IDLE, fetch_addr=RESET_PC, pc=RESET_PC.
- instr=0, instr_valid=0, imem_req=0, kill=0, redirect_addr=0.
REQ-031 reset SHALL take priority over every other input, including mid-fetch; an imem_ack arriving after reset SHALL be ignored per REQ-029.

Configuration
REQ-032 With macro IFETCH_FETCH_COUNT_EN defined, the block SHALL add output fetch_count (32 bits):
- Reset to 0.
- Increments by 1 on each REQ-019 capture.
- Wraps from 32'hFFFF_FFFF to 0.
REQ-033 Without IFETCH_FETCH_COUNT_EN, fetch_count and its register SHALL NOT exist.

Verification
REQ-034 Reset with RESET_PC=0x40, ack every request same-cycle, stall=0 -> pc sequence 0x40,0x44,0x48 with instr_valid=1 every second cycle, opcode=imem_rdata[31:26].
REQ-035 Ack delayed 3 cycles -> imem_addr stable for 4 cycles with imem_req=1, instr_valid rises the cycle after ack.
REQ-036 stall=1 for 5 cycles in HOLD with branch_taken pulsed -> instr/pc unchanged, no new request; after stall=0 the next fetch is pc+4.
REQ-037 HOLD, stall=0, branch_taken=1, target=0x103 -> next imem_addr=0x100.
REQ-038 REQ, branch_taken at target 0x200 two cycles before ack -> that ack's data is discarded, instr_valid stays 0, next imem_addr=0x200, and its data is delivered with pc=0x200.
REQ-039 pc=0xFFFF_FFFC consumed -> pc_plus4=0 and next imem_addr=0. Reset asserted mid-REQ -> outputs match REQ-030 and a stray ack is ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit with branch redirect and kill of in-flight fetches.
// Optional macro IFETCH_FETCH_COUNT_EN adds a 32-bit count of captured fetches (fetch_count).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_if.master        imem,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [5:0]           opcode,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4
`ifdef IFETCH_FETCH_COUNT_EN
  ,
  output logic [31:0]          fetch_count
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] target_aligned;

  assign target_aligned = branch_target & ~32'd3;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    kill_d       = kill_q;
    redirect_d   = redirect_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem.imem_ack) begin
          // A branch arriving with the ack is the newest redirect and wins over any pending kill.
          if (branch_taken) begin
            fetch_addr_d = target_aligned;
            kill_d       = 1'b0;
          end else if (kill_q) begin
            fetch_addr_d = redirect_q;
            kill_d       = 1'b0;
          end else begin
            instr_d = imem.imem_rdata;
            pc_d    = fetch_addr_q;
            valid_d = 1'b1;
            state_d = StHold;
          end
        end else if (branch_taken) begin
          kill_d     = 1'b1;
          redirect_d = target_aligned;
        end
      end
      StHold: begin
        if (!stall) begin
          valid_d      = 1'b0;
          state_d      = StReq;
          fetch_addr_d = branch_taken ? target_aligned : pc_q + 32'd4;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      valid_q      <= 1'b0;
      kill_q       <= 1'b0;
      redirect_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      kill_q       <= kill_d;
      redirect_q   <= redirect_d;
    end
  end

  assign imem.imem_req  = (state_q == StReq);
  assign imem.imem_addr = fetch_addr_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign opcode         = instr_q[31:26];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;

`ifdef IFETCH_FETCH_COUNT_EN
  logic        capture;
  logic [31:0] count_q;

  assign capture = (state_q == StReq) && imem.imem_ack && !kill_q && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (capture) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule
